// File: rtl/hazard_unit_mc.sv
// Decode-side hazard unit: E/M forwarding, one multi-cycle unit scoreboard,
// multi-cycle branch squash window and a saturating stall-cycle counter.
module hazard_unit_mc #(
  parameter int DATA_W    = 16,
  parameter int REG_AW    = 4,
  parameter int MUL_LAT   = 3,
  parameter int BR_SQUASH = 1,
  parameter int ZERO_REG  = 1,
  parameter int FWD_M_EN  = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branchD,
  input  logic [DATA_W-1:0] srcData1D,
  input  logic [DATA_W-1:0] srcData2D,
  input  logic              immediateD,
  input  logic              forwardEnD,
  input  logic              mulD,
  input  logic [REG_AW-1:0] srcAdd1D,
  input  logic [REG_AW-1:0] srcAdd2D,
  input  logic              RegWriteE,
  input  logic              MemToRegE,
  input  logic [REG_AW-1:0] destAddE,
  input  logic              mulStartE,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] destAddM,
  input  logic              flushExt,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD,
  output logic              flushE,
  output logic [1:0]        fwdA,
  output logic [1:0]        fwdB,
  output logic              InstBranch,
  output logic              mulBusy,
  output logic [CNT_W-1:0]  stallCount
);

  logic              mul_pend;
  logic [REG_AW-1:0] mul_dest;
  logic [3:0]        mul_cnt;
  logic [2:0]        br_cnt;

  logic use1, use2;
  logic mul_rdy, mul_wait;
  logic a_mul, a_e, a_m, b_mul, b_e, b_m;
  logic lw_stall, mul_raw_stall, mul_struct_stall, haz_stall;
  logic br_taken;

  function automatic logic addr_match(input logic [REG_AW-1:0] x,
                                      input logic [REG_AW-1:0] y);
    return (x == y) && !((ZERO_REG != 0) && (x == '0));
  endfunction

  // src2 is meaningless when decode substitutes the immediate
  assign use1 = forwardEnD;
  assign use2 = forwardEnD && !immediateD;

  assign mul_rdy  = mul_pend && (mul_cnt == 4'd0);
  assign mul_wait = mul_pend && (mul_cnt != 4'd0);

  assign a_mul = use1 && addr_match(srcAdd1D, mul_dest);
  assign b_mul = use2 && addr_match(srcAdd2D, mul_dest);
  assign a_e   = use1 && addr_match(srcAdd1D, destAddE);
  assign b_e   = use2 && addr_match(srcAdd2D, destAddE);
  assign a_m   = use1 && addr_match(srcAdd1D, destAddM);
  assign b_m   = use2 && addr_match(srcAdd2D, destAddM);

  always_comb begin
    fwdA = 2'b00;
    if (mul_rdy && a_mul)                           fwdA = 2'b11;
    else if (RegWriteE && !MemToRegE && a_e)        fwdA = 2'b01;
    else if ((FWD_M_EN != 0) && RegWriteM && a_m)   fwdA = 2'b10;
  end

  always_comb begin
    fwdB = 2'b00;
    if (mul_rdy && b_mul)                           fwdB = 2'b11;
    else if (RegWriteE && !MemToRegE && b_e)        fwdB = 2'b01;
    else if ((FWD_M_EN != 0) && RegWriteM && b_m)   fwdB = 2'b10;
  end

  assign lw_stall         = MemToRegE && (a_e || b_e);
  assign mul_raw_stall    = mul_wait && (a_mul || b_mul);
  // a new multi-cycle op may issue in the cycle before the unit frees up
  assign mul_struct_stall = mulD && mul_pend && (mul_cnt > 4'd1);
  assign haz_stall        = lw_stall || mul_raw_stall || mul_struct_stall;

  assign br_taken   = branchD && (srcData1D == srcData2D) && !haz_stall;
  assign InstBranch = br_taken;

  assign stallF  = haz_stall;
  assign stallD  = haz_stall;
  assign flushD  = br_taken || (br_cnt != 3'd0) || flushExt;
  assign flushE  = haz_stall || flushExt;
  assign mulBusy = mul_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_pend <= 1'b0;
      mul_dest <= '0;
      mul_cnt  <= 4'd0;
    end else if (mulStartE) begin
      mul_pend <= 1'b1;
      mul_dest <= destAddE;
      mul_cnt  <= 4'(MUL_LAT - 1);
    end else if (mul_wait) begin
      mul_cnt  <= mul_cnt - 4'd1;
    end else if (mul_pend) begin
      mul_pend <= 1'b0;
    end
  end

  // an external flush cancels any pending branch squash window
  always_ff @(posedge clk) begin
    if (reset || flushExt) br_cnt <= 3'd0;
    else if (br_taken)     br_cnt <= 3'(BR_SQUASH - 1);
    else if (br_cnt != 3'd0) br_cnt <= br_cnt - 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      stallCount <= '0;
    else if (haz_stall && (stallCount != {CNT_W{1'b1}}))
      stallCount <= stallCount + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: directed test-plan scenarios plus
// random stimulus against a timestamp-based reference model.
module tb_hazard_unit_mc;

  localparam int L_DW  = 16;
  localparam int L_AW  = 4;
  localparam int L_MUL = 3;
  localparam int L_BR  = 3;
  localparam int L_CW  = 4;
  localparam int L_SAT = 15;

  logic clk = 1'b0;
  logic reset;
  logic branchD;
  logic [L_DW-1:0] srcData1D, srcData2D;
  logic immediateD, forwardEnD, mulD;
  logic [L_AW-1:0] srcAdd1D, srcAdd2D;
  logic RegWriteE, MemToRegE;
  logic [L_AW-1:0] destAddE;
  logic mulStartE, RegWriteM;
  logic [L_AW-1:0] destAddM;
  logic flushExt;
  logic stallF, stallD, flushD, flushE;
  logic [1:0] fwdA, fwdB;
  logic InstBranch, mulBusy;
  logic [L_CW-1:0] stallCount;

  hazard_unit_mc #(
    .DATA_W(L_DW), .REG_AW(L_AW), .MUL_LAT(L_MUL), .BR_SQUASH(L_BR),
    .ZERO_REG(1), .FWD_M_EN(1), .CNT_W(L_CW)
  ) dut (
    .clk(clk), .reset(reset), .branchD(branchD),
    .srcData1D(srcData1D), .srcData2D(srcData2D),
    .immediateD(immediateD), .forwardEnD(forwardEnD), .mulD(mulD),
    .srcAdd1D(srcAdd1D), .srcAdd2D(srcAdd2D),
    .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .destAddE(destAddE),
    .mulStartE(mulStartE), .RegWriteM(RegWriteM), .destAddM(destAddM),
    .flushExt(flushExt),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .fwdA(fwdA), .fwdB(fwdB), .InstBranch(InstBranch), .mulBusy(mulBusy),
    .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: the multi-cycle op is tracked by its issue cycle and the
  // squash window by the last cycle it covers
  int  cyc = 0;
  bit  m_valid = 0;
  int  m_issue = 0;
  int  m_dest = 0;
  int  br_until = -1000;
  int  scount = 0;
  bit  e_haz, e_ib;

  function automatic bit mt(input int x, input int y);
    return (x == y) && (x != 0);
  endfunction

  function automatic int sel(input int src, input bit used, input bit ready);
    if (!used) return 0;
    if (ready && mt(src, m_dest)) return 3;
    if (RegWriteE && !MemToRegE && mt(src, int'(destAddE))) return 1;
    if (RegWriteM && mt(src, int'(destAddM))) return 2;
    return 0;
  endfunction

  task automatic check_cycle();
    int age, rem;
    bit u1, u2, ready, waiting, lw, raw, st, exp_fd;
    #1;
    age     = cyc - m_issue;
    rem     = L_MUL - age;
    ready   = m_valid && (rem == 0);
    waiting = m_valid && (rem > 0);
    u1 = forwardEnD;
    u2 = forwardEnD && !immediateD;
    lw  = MemToRegE && ((u1 && mt(srcAdd1D, destAddE)) || (u2 && mt(srcAdd2D, destAddE)));
    raw = waiting && ((u1 && mt(srcAdd1D, m_dest)) || (u2 && mt(srcAdd2D, m_dest)));
    st  = mulD && m_valid && (rem > 1);
    e_haz  = lw || raw || st;
    e_ib   = branchD && (srcData1D == srcData2D) && !e_haz;
    exp_fd = e_ib || (cyc <= br_until) || flushExt;
    chk("stallF", 32'(stallF), 32'(e_haz));
    chk("stallD", 32'(stallD), 32'(e_haz));
    chk("flushE", 32'(flushE), 32'(e_haz || flushExt));
    chk("flushD", 32'(flushD), 32'(exp_fd));
    chk("InstBranch", 32'(InstBranch), 32'(e_ib));
    chk("fwdA", 32'(fwdA), 32'(sel(srcAdd1D, u1, ready)));
    chk("fwdB", 32'(fwdB), 32'(sel(srcAdd2D, u2, ready)));
    chk("mulBusy", 32'(mulBusy), 32'(m_valid));
    chk("stallCount", 32'(stallCount), 32'(scount));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_valid  = 0;
      br_until = -1000;
      scount   = 0;
    end else begin
      if (mulStartE) begin
        m_valid = 1;
        m_issue = cyc;
        m_dest  = int'(destAddE);
      end else if (m_valid && (cyc - m_issue == L_MUL)) begin
        m_valid = 0;
      end
      if (flushExt)  br_until = cyc;
      else if (e_ib) br_until = cyc + L_BR - 1;
      if (e_haz && scount < L_SAT) scount++;
    end
    cyc++;
    #2;
  endtask

  task automatic idle();
    reset = 0; branchD = 0; srcData1D = '0; srcData2D = '0;
    immediateD = 0; forwardEnD = 0; mulD = 0; srcAdd1D = '0; srcAdd2D = '0;
    RegWriteE = 0; MemToRegE = 0; destAddE = '0; mulStartE = 0;
    RegWriteM = 0; destAddM = '0; flushExt = 0;
  endtask

  task automatic step();
    check_cycle();
    tick();
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    check_cycle();
    chk("rst_stallF", 32'(stallF), 32'd0);
    chk("rst_flushD", 32'(flushD), 32'd0);
    chk("rst_mulBusy", 32'(mulBusy), 32'd0);
    chk("rst_count", 32'(stallCount), 32'd0);
    tick();

    // load-use, then M forwarding once the load reaches memory
    idle(); forwardEnD = 1; MemToRegE = 1; RegWriteE = 1; destAddE = 4'd3; srcAdd1D = 4'd3;
    check_cycle();
    chk("lu_stall", 32'(stallF), 32'd1);
    chk("lu_flushE", 32'(flushE), 32'd1);
    chk("lu_fwdA", 32'(fwdA), 32'd0);
    tick();
    MemToRegE = 0; RegWriteE = 0; RegWriteM = 1; destAddM = 4'd3;
    check_cycle();
    chk("lu2_stall", 32'(stallF), 32'd0);
    chk("lu2_fwdA", 32'(fwdA), 32'd2);
    tick();

    // zero register and immediate masking
    idle(); forwardEnD = 1; RegWriteE = 1; destAddE = 4'd0; srcAdd1D = 4'd0;
    check_cycle();
    chk("zr_fwdA", 32'(fwdA), 32'd0);
    chk("zr_stall", 32'(stallF), 32'd0);
    tick();
    immediateD = 1; srcAdd2D = 4'd5; destAddE = 4'd5;
    check_cycle();
    chk("imm_fwdB", 32'(fwdB), 32'd0);
    tick();

    // multiplier RAW: stall, stall, forward 11, then free
    idle(); mulStartE = 1; destAddE = 4'd7; step();
    idle(); forwardEnD = 1; srcAdd1D = 4'd7;
    check_cycle(); chk("mul_c1_stall", 32'(stallF), 32'd1); tick();
    check_cycle(); chk("mul_c2_stall", 32'(stallF), 32'd1); tick();
    check_cycle(); chk("mul_c3_stall", 32'(stallF), 32'd0);
    chk("mul_c3_fwdA", 32'(fwdA), 32'd3); tick();
    check_cycle(); chk("mul_c4_busy", 32'(mulBusy), 32'd0); tick();

    // structural hazard on the multiplier
    idle(); mulStartE = 1; destAddE = 4'd7; step();
    idle(); mulD = 1;
    check_cycle(); chk("mst_c1_stall", 32'(stallF), 32'd1); tick();
    check_cycle(); chk("mst_c2_stall", 32'(stallF), 32'd0); tick();
    idle(); step(); step();

    // reset mid-op drops the entry
    idle(); mulStartE = 1; destAddE = 4'd7; step();
    idle(); reset = 1; step();
    idle(); forwardEnD = 1; srcAdd1D = 4'd7;
    check_cycle(); chk("mrst_busy", 32'(mulBusy), 32'd0);
    chk("mrst_stall", 32'(stallF), 32'd0); tick();

    // taken branch squash window of three cycles
    idle(); branchD = 1; srcData1D = 16'h00A5; srcData2D = 16'h00A5;
    check_cycle(); chk("br_ib", 32'(InstBranch), 32'd1); chk("br_fd0", 32'(flushD), 32'd1); tick();
    idle();
    check_cycle(); chk("br_fd1", 32'(flushD), 32'd1); tick();
    check_cycle(); chk("br_fd2", 32'(flushD), 32'd1); tick();
    check_cycle(); chk("br_fd3", 32'(flushD), 32'd0); tick();

    // second branch in the window extends it
    branchD = 1; srcData1D = 16'h00A5; srcData2D = 16'h00A5; step(); step();
    idle();
    check_cycle(); chk("br2_fd2", 32'(flushD), 32'd1); tick();
    check_cycle(); chk("br2_fd3", 32'(flushD), 32'd1); tick();
    check_cycle(); chk("br2_fd4", 32'(flushD), 32'd0); tick();

    branchD = 1; srcData1D = 16'h00A5; srcData2D = 16'h00A4;
    check_cycle(); chk("brne_ib", 32'(InstBranch), 32'd0); tick();

    // branch held back by a load-use hazard
    idle(); branchD = 1; srcData1D = 16'h1234; srcData2D = 16'h1234;
    forwardEnD = 1; MemToRegE = 1; destAddE = 4'd2; srcAdd1D = 4'd2;
    check_cycle(); chk("brh_ib", 32'(InstBranch), 32'd0);
    chk("brh_fd", 32'(flushD), 32'd0); chk("brh_stallD", 32'(stallD), 32'd1); tick();

    // stall counter and saturation
    do_reset();
    idle(); forwardEnD = 1; MemToRegE = 1; destAddE = 4'd9; srcAdd2D = 4'd9;
    repeat (5) step();
    idle(); check_cycle(); chk("cnt5", 32'(stallCount), 32'd5); tick();
    forwardEnD = 1; MemToRegE = 1; destAddE = 4'd9; srcAdd2D = 4'd9;
    repeat (15) step();
    idle(); check_cycle(); chk("cnt_sat", 32'(stallCount), 32'd15); tick();
    reset = 1; step(); reset = 0;
    check_cycle(); chk("cnt_rst", 32'(stallCount), 32'd0); tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 39) == 0);
      branchD    = $urandom_range(0, 1);
      srcData1D  = 16'($urandom_range(0, 3));
      srcData2D  = ($urandom_range(0, 1) == 1) ? srcData1D : 16'($urandom_range(0, 3));
      immediateD = ($urandom_range(0, 3) == 0);
      forwardEnD = ($urandom_range(0, 4) != 0);
      mulD       = ($urandom_range(0, 4) == 0);
      srcAdd1D   = 4'($urandom_range(0, 7));
      srcAdd2D   = 4'($urandom_range(0, 7));
      RegWriteE  = $urandom_range(0, 1);
      MemToRegE  = ($urandom_range(0, 3) == 0);
      destAddE   = 4'($urandom_range(0, 7));
      mulStartE  = ($urandom_range(0, 6) == 0);
      RegWriteM  = $urandom_range(0, 1);
      destAddM   = 4'($urandom_range(0, 7));
      flushExt   = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Parametrised successor to the pipeline hazard unit. It adds the following:
- Two-level forwarding (E and M), with M-stage forwarding optional.
- A scoreboard for one multi-cycle execute unit (multiplier) with fixed latency MUL_LAT.
- A multi-cycle branch-redirect squash window.
- A saturating stall-cycle performance counter.

It sits beside the decode stage. Its outputs drive the F/D pipeline-register enables, the D/E flush, and the decode-stage operand muxes.

Parameters:
DATA_W, 16, width of compared branch operands
REG_AW, 4, register address width
MUL_LAT, 3, multi-cycle unit latency in cycles (legal 2..15)
BR_SQUASH, 1, cycles flushD stays asserted after a taken branch (legal 1..7)
ZERO_REG, 1, when 1, register address 0 never forwards or stalls
FWD_M_EN, 1, when 0, fwdA/fwdB never select M
CNT_W, 16, perf counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
branchD  in  1  decode instruction is a conditional branch (beq)
srcData1D, srcData2D  in  DATA_W  post-forward branch operands
immediateD  in  1  decode uses immediate in place of src2
forwardEnD  in  1  decode instruction reads registers
mulD  in  1  decode instruction is a multi-cycle op
srcAdd1D, srcAdd2D  in  REG_AW  decode source addresses
RegWriteE, MemToRegE  in  1  execute-stage controls
destAddE  in  REG_AW  execute destination
mulStartE  in  1  multi-cycle op is in execute this cycle
RegWriteM  in  1  memory-stage write enable
destAddM  in  REG_AW  memory destination
flushExt  in  1  external flush (exception/interrupt)
stallF, stallD  out  1  hold PC / F-D register
flushD, flushE  out  1  clear F-D / D-E register
fwdA, fwdB  out  2  operand select: 00 regfile, 01 E, 10 M, 11 multi-cycle result
InstBranch  out  1  taken branch accepted this cycle
mulBusy  out  1  scoreboard entry valid
stallCount  out  CNT_W  stall cycles since reset

Behaviour:
- Address match m(x,y) = (x==y) and not (ZERO_REG and x==0). src2 terms are ignored when immediateD=1. All terms are gated by forwardEnD.
- Scoreboard registers: mulPend, mulDest[REG_AW], mulCnt[4].
  - On mulStartE: mulPend<=1, mulDest<=destAddE, mulCnt<=MUL_LAT-1.
  - Else if mulPend and mulCnt!=0: mulCnt decrements.
  - Else if mulPend and mulCnt==0: mulPend<=0. This is the result/writeback cycle.
  - mulStartE has priority over the writeback clear in the same cycle.
- mulBusy = mulPend.
- Forward select, per source, first match wins:
  1. Scoreboard: mulPend, mulCnt==0, m(src,mulDest) -> 11.
  2. E: RegWriteE, !MemToRegE, m(src,destAddE) -> 01.
  3. M: FWD_M_EN, RegWriteM, m(src,destAddM) -> 10.
  4. Otherwise -> 00.
- lwStall = MemToRegE and m(src,destAddE) on any used source.
- mulRawStall = mulPend and mulCnt!=0 and m(src,mulDest) on any used source.
- mulStructStall = mulD and mulPend and mulCnt>1. Issue is allowed when the unit frees next cycle.
- hazStall = lwStall | mulRawStall | mulStructStall.
- InstBranch = branchD and srcData1D==srcData2D and !hazStall. Branches are evaluated only when operands are valid.
- Squash counter brCnt[3]:
  - On InstBranch, brCnt<=BR_SQUASH-1.
  - Else it decrements while nonzero.
  - flushD = InstBranch | (brCnt!=0) | flushExt.
  - A new InstBranch during the window reloads the counter.
- stallF = stallD = hazStall. Stall holds F/D and does not squash, so flushD only clears F-D when stall is low.
- flushE = hazStall | flushExt. This inserts a bubble.
- flushExt does not cancel an in-flight multi-cycle op. It clears brCnt<=0 the next cycle.
- stallCount increments by 1 in every cycle with stallF=1 and saturates at all-ones.
- Reset (synchronous, dominant over all updates):
  - mulPend=0, mulDest=0, mulCnt=0, brCnt=0, stallCount=0.
  - All outputs are then 0 provided inputs are idle.
  - Reset asserted mid multi-cycle op drops the entry; no stall follows.
- Latency: forward/stall/branch outputs are combinational from the current-cycle inputs. Registered state affects outputs from the next cycle.

Test Plan:
- Load-use: MemToRegE=1, destAddE=3, srcAdd1D=3, forwardEnD=1 -> stallF=stallD=flushE=1, fwdA=00; next cycle MemToRegE=0, RegWriteM=1, destAddM=3 -> stall=0, fwdA=10.
- Zero register: RegWriteE=1, destAddE=0, srcAdd1D=0, ZERO_REG=1 -> fwdA=00, no stall; and with immediateD=1, srcAdd2D=destAddE=5 -> fwdB=00.
- Multiplier MUL_LAT=3: mulStartE with destAddE=7 at cycle 0; srcAdd1D=7 in cycles 1,2 -> stall=1 (mulCnt=2,1); cycle 3 -> stall=0, fwdA=11; cycle 4 -> mulBusy=0. mulD in cycle 1 -> stall; mulD in cycle 2 -> no stall. Reset in cycle 1 -> mulBusy=0 in cycle 2, no stall.
- Taken branch with BR_SQUASH=3: branchD=1, srcData1D=srcData2D=16'h00A5 -> InstBranch=1, flushD=1 for 3 consecutive cycles; a second taken branch in cycle 1 extends the window to cycle 3. Operands 16'h00A5/16'h00A4 -> InstBranch=0.
- Branch under hazard: branchD=1, equal data, lwStall=1 -> InstBranch=0, flushD=0, stallD=1.
- Counter: hold lwStall for 5 cycles -> stallCount=5. With CNT_W=4 and 20 stall cycles -> stallCount=15 (saturated). Reset -> 0.
